// File: rtl/otter_pkg.sv
// Shared definitions for the OTTER control unit.
// State encodings are fixed so fsm_state stays readable in debug.
package otter_pkg;

    typedef enum logic [2:0] {
        ST_INIT  = 3'd0,
        ST_FETCH = 3'd1,
        ST_EXEC  = 3'd2,
        ST_WB    = 3'd3,
        ST_INTR  = 3'd4,
        ST_HALT  = 3'd5
    } cu_state_e;

    localparam logic [6:0] LOAD   = 7'b0000011;
    localparam logic [6:0] STORE  = 7'b0100011;
    localparam logic [6:0] BRANCH = 7'b1100011;
    localparam logic [6:0] SYSTEM = 7'b1110011;
    localparam logic [6:0] OP     = 7'b0110011;
    localparam logic [6:0] OP_IMM = 7'b0010011;
    localparam logic [6:0] LUI    = 7'b0110111;
    localparam logic [6:0] AUIPC  = 7'b0010111;
    localparam logic [6:0] JAL    = 7'b1101111;
    localparam logic [6:0] JALR   = 7'b1100111;

    localparam logic [2:0] F3_PRIV = 3'b000;

    function automatic logic is_csr_f3(input logic [2:0] f3);
        return (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b011);
    endfunction

endpackage

// File: rtl/otter_cu_fsm.sv
// Multi-cycle control FSM for the OTTER RV32I core.
// Sequences fetch/exec/writeback/interrupt entry with a memory stall watchdog.
module otter_cu_fsm
    import otter_pkg::*;
#(
    parameter int STALL_MAX = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic [6:0] ir_opcode,
    input  logic [2:0] ir_funct3,
    input  logic       intr,
    input  logic       mie,
    input  logic       imem_ready,
    input  logic       dmem_ready,
    output logic       PCWrite,
    output logic       regWrite,
    output logic       memRDEN1,
    output logic       memRDEN2,
    output logic       memWE2,
    output logic       rst_out,
    output logic       csr_WE,
    output logic       int_taken,
    output logic       mret_exec,
    output logic       mem_timeout,
    output logic [2:0] fsm_state
);

    localparam int CW = $clog2(STALL_MAX);

    cu_state_e     state_q, state_d;
    logic [CW-1:0] stall_cnt_q, stall_cnt_d;
    logic          mem_timeout_q, mem_timeout_d;

    logic      is_load, is_store, is_mret, is_csr, is_rd;
    logic      waiting, ready, stalled, limit;
    cu_state_e exit_st;

    always_comb begin
        is_load  = (ir_opcode == LOAD);
        is_store = (ir_opcode == STORE);
        is_mret  = (ir_opcode == SYSTEM) && (ir_funct3 == F3_PRIV);
        is_csr   = (ir_opcode == SYSTEM) && is_csr_f3(ir_funct3);
        is_rd    = (ir_opcode == OP)    || (ir_opcode == OP_IMM)
                || (ir_opcode == LUI)   || (ir_opcode == AUIPC)
                || (ir_opcode == JAL)   || (ir_opcode == JALR);
    end

    // Interrupts are only taken at instruction boundaries.
    assign exit_st = (intr && mie) ? ST_INTR : ST_FETCH;

    always_comb begin
        waiting = 1'b0;
        ready   = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                waiting = 1'b1;
                ready   = imem_ready;
            end
            ST_EXEC: begin
                waiting = is_store;
                ready   = dmem_ready;
            end
            ST_WB: begin
                waiting = 1'b1;
                ready   = dmem_ready;
            end
            default: ;
        endcase
    end

    assign stalled = waiting && !ready;
    assign limit   = stalled && (stall_cnt_q == CW'(STALL_MAX - 1));

    always_comb begin
        state_d   = state_q;
        PCWrite   = 1'b0;
        regWrite  = 1'b0;
        memRDEN1  = 1'b0;
        memRDEN2  = 1'b0;
        memWE2    = 1'b0;
        rst_out   = 1'b0;
        csr_WE    = 1'b0;
        int_taken = 1'b0;
        mret_exec = 1'b0;
        unique case (state_q)
            ST_INIT: begin
                rst_out = 1'b1;
                state_d = ST_FETCH;
            end
            ST_FETCH: begin
                memRDEN1 = 1'b1;
                if (imem_ready) state_d = ST_EXEC;
            end
            ST_EXEC: begin
                unique case (1'b1)
                    is_load: begin
                        memRDEN2 = 1'b1;
                        state_d  = ST_WB;
                    end
                    is_store: begin
                        memWE2 = 1'b1;
                        if (dmem_ready) begin
                            PCWrite = 1'b1;
                            state_d = exit_st;
                        end
                    end
                    // mie is still the pre-restore value here.
                    is_mret: begin
                        mret_exec = 1'b1;
                        PCWrite   = 1'b1;
                        state_d   = ST_FETCH;
                    end
                    is_csr: begin
                        csr_WE   = 1'b1;
                        regWrite = 1'b1;
                        PCWrite  = 1'b1;
                        state_d  = exit_st;
                    end
                    is_rd: begin
                        regWrite = 1'b1;
                        PCWrite  = 1'b1;
                        state_d  = exit_st;
                    end
                    default: begin
                        PCWrite = 1'b1;
                        state_d = exit_st;
                    end
                endcase
            end
            ST_WB: begin
                if (dmem_ready) begin
                    regWrite = 1'b1;
                    PCWrite  = 1'b1;
                    state_d  = exit_st;
                end
            end
            ST_INTR: begin
                int_taken = 1'b1;
                PCWrite   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: ;
            default: state_d = ST_INIT;
        endcase
        if (limit) state_d = ST_HALT;
    end

    always_comb begin
        stall_cnt_d   = '0;
        mem_timeout_d = mem_timeout_q || limit;
        if (stalled && !limit) stall_cnt_d = stall_cnt_q + CW'(1);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q       <= ST_INIT;
            stall_cnt_q   <= '0;
            mem_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            stall_cnt_q   <= stall_cnt_d;
            mem_timeout_q <= mem_timeout_d;
        end
    end

    assign mem_timeout = mem_timeout_q;
    assign fsm_state   = state_q;

endmodule

// File: tb/tb_otter_cu_fsm.sv
// Bench for otter_cu_fsm: directed scenarios plus random traffic,
// every cycle compared against a behavioural model of the control unit.
module tb_otter_cu_fsm;

    localparam int SM = 16;

    logic       CLK = 1'b0;
    logic       RST;
    logic [6:0] ir_opcode;
    logic [2:0] ir_funct3;
    logic       intr, mie, imem_ready, dmem_ready;
    logic       PCWrite, regWrite, memRDEN1, memRDEN2, memWE2;
    logic       rst_out, csr_WE, int_taken, mret_exec, mem_timeout;
    logic [2:0] fsm_state;
    logic [9:0] outs_vec;

    otter_cu_fsm #(.STALL_MAX(SM)) dut (
        .CLK(CLK), .RST(RST),
        .ir_opcode(ir_opcode), .ir_funct3(ir_funct3),
        .intr(intr), .mie(mie),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready),
        .PCWrite(PCWrite), .regWrite(regWrite),
        .memRDEN1(memRDEN1), .memRDEN2(memRDEN2), .memWE2(memWE2),
        .rst_out(rst_out), .csr_WE(csr_WE),
        .int_taken(int_taken), .mret_exec(mret_exec),
        .mem_timeout(mem_timeout), .fsm_state(fsm_state)
    );

    always #5 CLK = ~CLK;

    assign outs_vec = {PCWrite, regWrite, memRDEN1, memRDEN2, memWE2,
                       rst_out, csr_WE, int_taken, mret_exec, mem_timeout};

    int n_chk  = 0;
    int n_pass = 0;

    // model: state number, consecutive stalled cycles, sticky timeout
    int m_st   = 0;
    int m_wait = 0;
    bit m_to   = 0;

    localparam int K_LOAD = 0, K_STORE = 1, K_MRET = 2;
    localparam int K_CSR = 3, K_RD = 4, K_PC = 5;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at %0t: got %0h expected %0h",
                      tag, $time, got, exp);
    endtask

    function automatic int kind(input logic [6:0] op, input logic [2:0] f3);
        if (op == 7'b0000011) return K_LOAD;
        if (op == 7'b0100011) return K_STORE;
        if (op == 7'b1110011) begin
            if (f3 == 3'd0) return K_MRET;
            if (f3 >= 3'd1 && f3 <= 3'd3) return K_CSR;
            return K_PC;
        end
        if (op inside {7'b0110011, 7'b0010011, 7'b0110111,
                       7'b0010111, 7'b1101111, 7'b1100111}) return K_RD;
        return K_PC;
    endfunction

    function automatic logic [9:0] exp_outs();
        logic pc = 0, rw = 0, r1 = 0, r2 = 0, we = 0;
        logic ro = 0, cw = 0, it = 0, mr = 0;
        int k = kind(ir_opcode, ir_funct3);
        case (m_st)
            0: ro = 1;
            1: r1 = 1;
            2: begin
                case (k)
                    K_LOAD:  r2 = 1;
                    K_STORE: begin we = 1; pc = dmem_ready; end
                    K_MRET:  begin mr = 1; pc = 1; end
                    K_CSR:   begin cw = 1; rw = 1; pc = 1; end
                    K_RD:    begin rw = 1; pc = 1; end
                    default: pc = 1;
                endcase
            end
            3: begin pc = dmem_ready; rw = dmem_ready; end
            4: begin it = 1; pc = 1; end
            default: ;
        endcase
        return {pc, rw, r1, r2, we, ro, cw, it, mr, m_to};
    endfunction

    task automatic m_step();
        int  nxt   = m_st;
        bit  stall = 0;
        bit  irq   = intr && mie;
        int  k     = kind(ir_opcode, ir_funct3);
        if (RST) begin
            m_st = 0; m_wait = 0; m_to = 0;
            return;
        end
        case (m_st)
            0: nxt = 1;
            1: if (imem_ready) nxt = 2; else stall = 1;
            2: begin
                if (k == K_LOAD) nxt = 3;
                else if (k == K_STORE && !dmem_ready) stall = 1;
                else nxt = (k != K_MRET && irq) ? 4 : 1;
            end
            3: if (dmem_ready) nxt = irq ? 4 : 1; else stall = 1;
            4: nxt = 1;
            default: nxt = 5;
        endcase
        if (stall) begin
            m_wait++;
            if (m_wait >= SM) begin
                nxt  = 5;
                m_to = 1;
            end
        end
        if (!stall || nxt != m_st) m_wait = 0;
        m_st = nxt;
    endtask

    task automatic tick();
        @(negedge CLK);
        check("state", 32'(fsm_state), 32'(m_st));
        check("outs", 32'(outs_vec), 32'(exp_outs()));
        check("onehot",
              32'($countones({memRDEN1, memRDEN2, memWE2}) <= 1), 32'd1);
        @(posedge CLK);
        m_step();
        #1;
    endtask

    task automatic run(input int n);
        repeat (n) tick();
    endtask

    task automatic set_in(input logic [6:0] op, input logic [2:0] f3,
                          input logic it, input logic me,
                          input logic ir, input logic dr);
        ir_opcode  = op;
        ir_funct3  = f3;
        intr       = it;
        mie        = me;
        imem_ready = ir;
        dmem_ready = dr;
    endtask

    task automatic do_reset();
        RST    = 1'b1;
        m_st   = 0;
        m_wait = 0;
        m_to   = 0;
        tick();
        tick();
        RST = 1'b0;
    endtask

    logic [6:0] ops [12];
    int         ps  [5];

    initial begin
        RST = 1'b0;
        set_in(7'b0110011, 3'd0, 0, 0, 1, 1);
        #1;

        // ADD with imem tied ready
        do_reset();
        run(4);

        // LOAD, three not-ready WB cycles
        do_reset();
        set_in(7'b0000011, 3'd2, 0, 0, 1, 0);
        run(3);
        run(3);
        dmem_ready = 1;
        run(2);

        // STORE, ready two cycles late
        do_reset();
        set_in(7'b0100011, 3'd2, 0, 0, 1, 0);
        run(2);
        run(2);
        dmem_ready = 1;
        run(2);

        // interrupt at an ADD boundary, then masked
        do_reset();
        set_in(7'b0110011, 3'd0, 1, 1, 1, 1);
        run(3);
        check("intr_entry", 32'(fsm_state), 32'd4);
        run(2);
        do_reset();
        mie = 0;
        run(3);
        check("intr_masked", 32'(fsm_state), 32'd1);

        // mret ignores a pending interrupt; csrrw writes
        do_reset();
        set_in(7'b1110011, 3'd0, 1, 1, 1, 1);
        run(3);
        check("mret_fetch", 32'(fsm_state), 32'd1);
        set_in(7'b1110011, 3'd1, 0, 0, 1, 1);
        run(3);

        // watchdog: 16 starved fetch cycles halt
        do_reset();
        set_in(7'b0110011, 3'd0, 0, 0, 0, 0);
        run(1);
        run(16);
        check("halt16", 32'(fsm_state), 32'd5);
        check("timeout_set", 32'(mem_timeout), 32'd1);
        imem_ready = 1;
        run(4);
        check("timeout_sticky", 32'(mem_timeout), 32'd1);
        do_reset();
        check("timeout_clr", 32'(mem_timeout), 32'd0);

        // ready arrives on the 16th fetch cycle
        imem_ready = 0;
        run(1);
        run(15);
        imem_ready = 1;
        run(1);
        check("ready16", 32'(fsm_state), 32'd2);

        ops = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1110011,
                7'b0110011, 7'b0010011, 7'b0110111, 7'b0010111,
                7'b1101111, 7'b1100111, 7'b0, 7'b0};
        ps  = '{0, 30, 60, 90, 100};
        for (int blk = 0; blk < 60; blk++) begin
            int p = ps[$urandom_range(0, 4)];
            for (int c = 0; c < 64; c++) begin
                int idx = $urandom_range(0, 11);
                if ((m_st == 5 && $urandom_range(0, 3) == 0) ||
                    $urandom_range(0, 199) == 0)
                    do_reset();
                ir_opcode  = (idx >= 10) ? 7'($urandom) : ops[idx];
                ir_funct3  = 3'($urandom);
                intr       = ($urandom_range(0, 99) < 30);
                mie        = ($urandom_range(0, 1) == 1);
                imem_ready = ($urandom_range(0, 99) < p);
                dmem_ready = ($urandom_range(0, 99) < p);
                tick();
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/otter_cu_fsm.md
Name: otter_cu_fsm

Overview:
- Multi-cycle control state machine for the OTTER RV32I core; sequences fetch, execute, load writeback and interrupt entry.
- Sits beside the combinational decoder. It issues the datapath write enables, memory strobes and CSR controls that the decoder does not.
- Supports variable-latency instruction and data memories through ready handshakes.
- A stall watchdog halts the core if a memory never responds.

Parameters:
- STALL_MAX, 16: maximum consecutive not-ready cycles tolerated in any wait before the FSM halts. Legal range is 2..255.

Ports:
- CLK  in  1  core clock; all state updates on the rising edge.
- RST  in  1  asynchronous, active-high reset.
- ir_opcode  in  7  instruction bits 6:0 (valid in EXEC).
- ir_funct3  in  3  instruction bits 14:12 (valid in EXEC).
- intr  in  1  external interrupt request, level, synchronous to CLK.
- mie  in  1  CSR mstatus.MIE; interrupts are taken only when 1.
- imem_ready  in  1  instruction memory data valid.
- dmem_ready  in  1  data memory read data valid or write accepted.
- PCWrite  out  1  PC register load enable.
- regWrite  out  1  register file write enable.
- memRDEN1  out  1  instruction fetch read strobe.
- memRDEN2  out  1  data read strobe.
- memWE2  out  1  data write strobe.
- rst_out  out  1  reset to PC and datapath.
- csr_WE  out  1  CSR file write enable.
- int_taken  out  1  interrupt entry pulse; the CSR file saves mepc and clears MIE.
- mret_exec  out  1  mret pulse; the CSR file restores MIE.
- mem_timeout  out  1  sticky watchdog flag.
- fsm_state  out  3  current state encoding, for debug.

Behaviour:
- States and encodings: INIT=0, FETCH=1, EXEC=2, WB=3, INTR=4, HALT=5.
- All outputs are Moore/Mealy combinational from the state, except mem_timeout and stall_cnt, which are registered.
- While RST=1: state=INIT, stall_cnt=0, mem_timeout=0. All outputs are 0 except rst_out=1 and fsm_state=0.
- Default for every output each cycle is 0.
- INIT: rst_out=1. Next state is FETCH.
- FETCH: memRDEN1=1.
  - imem_ready=1 -> EXEC.
  - Otherwise stay in FETCH.
- EXEC, decode on ir_opcode:
  - LOAD (0000011): memRDEN2=1. Next state is WB unconditionally.
  - STORE (0100011): memWE2=1 is held every cycle until dmem_ready=1. In that cycle PCWrite=1 and the FSM exits. While waiting it stays in EXEC.
  - BRANCH (1100011): PCWrite=1, regWrite=0.
  - SYSTEM (1110011), funct3=000: treated as mret. mret_exec=1, PCWrite=1.
  - SYSTEM, funct3 in {001,010,011}: csr_WE=1, regWrite=1, PCWrite=1.
  - SYSTEM, other funct3: PCWrite=1 only.
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: PCWrite=1, regWrite=1.
  - Any other opcode: PCWrite=1 only (executes as a nop).
- WB: wait for dmem_ready. On dmem_ready=1: regWrite=1, PCWrite=1, then exit. Otherwise stay in WB.
- Exit rule, shared by EXEC (all non-LOAD cases) and WB:
  - Next state is INTR if intr & mie, else FETCH.
  - Exception: the mret cycle always goes to FETCH and ignores the interrupt, because mie is pre-update.
- INTR: int_taken=1, PCWrite=1 (the PC mux selects mtvec, which is outside this block). Next state is FETCH.
- Interrupts are sampled only at instruction boundaries. intr asserted during FETCH or a memory wait is not lost if it is still high at the exit.
- Watchdog (stall_cnt):
  - Increments each cycle the FSM stays in FETCH with imem_ready=0, in WB with dmem_ready=0, or in STORE-EXEC with dmem_ready=0.
  - Clears on any state transition and whenever ready=1.
  - If stall_cnt == STALL_MAX-1 and ready is still 0 -> HALT, with mem_timeout set on the same edge.
  - Counter width is clog2(STALL_MAX).
- HALT: all strobes 0, mem_timeout=1. Only RST exits.
- Simultaneous events:
  - ready=1 on the same cycle the counter reaches its limit: ready wins and there is no halt.
  - RST asserted mid-wait: immediate INIT. Outstanding memory strobes drop asynchronously.
- A legal path never asserts more than one of memRDEN1, memRDEN2 or memWE2 at a time.

Decomposition:
- Shared package otter_pkg holds:
  - typedef enum for the FSM states, using the fixed encodings above.
  - Opcode localparams: LOAD, STORE, BRANCH, SYSTEM, OP, OP_IMM, LUI, AUIPC, JAL, JALR.
  - The funct3 constant for mret/ecall group 000.
- No sub-module is needed. The watchdog counter stays inline.

Test Plan:
- Reset release, imem_ready tied 1, ir_opcode=0110011: cycle 0 INIT with rst_out=1; cycle 1 FETCH with memRDEN1=1; cycle 2 EXEC with PCWrite=1 and regWrite=1; cycle 3 FETCH.
- LOAD with dmem_ready low for 3 cycles in WB: memRDEN2=1 for one EXEC cycle; regWrite and PCWrite pulse exactly once, on the 4th WB cycle.
- STORE with dmem_ready delayed 2 cycles: memWE2 held 3 cycles; PCWrite=1 only in the last; regWrite never asserts.
- intr=1, mie=1 during an ADD: EXEC -> INTR with int_taken=1 and PCWrite=1 -> FETCH. Repeat with mie=0: no INTR.
- mret (1110011/000) with intr=1, mie=1: mret_exec=1, next state FETCH, int_taken stays 0. csrrw (funct3=001): csr_WE=1 and regWrite=1.
- STALL_MAX=16 with imem_ready held 0: after 16 FETCH cycles the state is HALT and mem_timeout=1 stays sticky. Variant with ready=1 on the 16th cycle: EXEC, no halt. RST clears the flag.
